// File: rtl/copy_pkg.sv
// Shared encodings for the block copy engine FSM.
// StFill exists only when COPY_FILL_EN is defined.
package copy_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StRead  = 3'd1,
        StWrite = 3'd2,
        StDone  = 3'd3
`ifdef COPY_FILL_EN
        ,
        StFill  = 3'd4
`endif
    } copy_state_t;

endpackage

// File: rtl/block_copy_engine.sv
// Word-at-a-time memory block copy: READ into a hold register, then WRITE, per word.
// Optional fill mode (one word per cycle) is enabled by defining COPY_FILL_EN.
module block_copy_engine #(
    parameter int unsigned W = 8,
    parameter int unsigned A = 8
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic [A-1:0] SrcAddr,
    input  logic [A-1:0] DstAddr,
    input  logic [A-1:0] Length,
`ifdef COPY_FILL_EN
    input  logic         Fill,
    input  logic [W-1:0] FillValue,
`endif
    output logic         Busy,
    output logic         Done,
    output logic [A-1:0] MemAddress,
    output logic         MemWriteEn,
    output logic [W-1:0] MemWrData,
    input  logic [W-1:0] MemRdData
);
    import copy_pkg::*;

    copy_state_t  state_q, state_d;
    logic [A-1:0] src_q, src_d;
    logic [A-1:0] dst_q, dst_d;
    logic [A-1:0] len_q, len_d;
    logic [A-1:0] idx_q, idx_d;
    logic [W-1:0] hold_q, hold_d;
    logic [A-1:0] idx_inc;

    assign idx_inc = idx_q + A'(1);

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        dst_d      = dst_q;
        len_d      = len_q;
        idx_d      = idx_q;
        hold_d     = hold_q;
        Busy       = 1'b0;
        Done       = 1'b0;
        MemAddress = '0;
        MemWriteEn = 1'b0;
        MemWrData  = '0;
        unique case (state_q)
            StIdle: begin
                if (Start) begin
                    src_d = SrcAddr;
                    dst_d = DstAddr;
                    len_d = Length;
                    idx_d = '0;
`ifdef COPY_FILL_EN
                    if (Fill) begin
                        // The hold register doubles as the fill pattern source.
                        hold_d  = FillValue;
                        state_d = (Length == '0) ? StDone : StFill;
                    end else begin
                        state_d = (Length == '0) ? StDone : StRead;
                    end
`else
                    state_d = (Length == '0) ? StDone : StRead;
`endif
                end
            end
            StRead: begin
                Busy       = 1'b1;
                MemAddress = src_q + idx_q;
                hold_d     = MemRdData;
                state_d    = StWrite;
            end
            StWrite: begin
                Busy       = 1'b1;
                MemAddress = dst_q + idx_q;
                MemWrData  = hold_q;
                MemWriteEn = 1'b1;
                idx_d      = idx_inc;
                state_d    = (idx_inc == len_q) ? StDone : StRead;
            end
`ifdef COPY_FILL_EN
            StFill: begin
                Busy       = 1'b1;
                MemAddress = dst_q + idx_q;
                MemWrData  = hold_q;
                MemWriteEn = 1'b1;
                idx_d      = idx_inc;
                state_d    = (idx_inc == len_q) ? StDone : StFill;
            end
`endif
            StDone: begin
                Done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= StIdle;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
        end
    end

endmodule

// File: tb/tb_block_copy_engine.sv
// Directed bench for block_copy_engine with a behavioural 256-word memory.
// Fill-mode scenario is built only when COPY_FILL_EN is defined.
module tb_block_copy_engine;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] src = '0;
    logic [7:0] dst = '0;
    logic [7:0] len = '0;
    logic       busy, done, we;
    logic [7:0] addr, wdata, rdata;
`ifdef COPY_FILL_EN
    logic       fill = 1'b0;
    logic [7:0] fill_value = '0;
`endif

    logic [7:0] mem [256];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign rdata = mem[addr];
    always @(posedge clk) if (we) mem[addr] <= wdata;

    block_copy_engine #(.W(8), .A(8)) dut (
        .Clk(clk),
        .Reset(rst),
        .Start(start),
        .SrcAddr(src),
        .DstAddr(dst),
        .Length(len),
`ifdef COPY_FILL_EN
        .Fill(fill),
        .FillValue(fill_value),
`endif
        .Busy(busy),
        .Done(done),
        .MemAddress(addr),
        .MemWriteEn(we),
        .MemWrData(wdata),
        .MemRdData(rdata)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1 time unit into the first cycle after the Start edge.
    task automatic start_op(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l);
        src = s; dst = d; len = l; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int c0, output int cyc, output int busy_cnt);
        cyc = c0;
        busy_cnt = 0;
        while (!done && cyc < 60) begin
            if (busy) busy_cnt++;
            step();
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        total++; if (busy !== 1'b0)  begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0)  begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (we !== 1'b0)    begin bad++; $display("FAIL reset_we got=%b exp=0", we); end
        total++; if (addr !== 8'h00) begin bad++; $display("FAIL reset_addr got=%h exp=00", addr); end
        total++; if (wdata !== 8'h00) begin bad++; $display("FAIL reset_wdata got=%h exp=00", wdata); end
    endtask

    task automatic test_copy();
        int cyc, bc, bc0;
        logic [7:0] exp [4] = '{8'd11, 8'd22, 8'd33, 8'd44};
        for (int i = 0; i < 4; i++) mem[8'h10 + i] = exp[i];
        for (int i = 0; i < 5; i++) mem[8'h80 + i] = 8'h00;
        start_op(8'h10, 8'h80, 8'd4);
        total++; if (addr !== 8'h10 || we !== 1'b0) begin
            bad++; $display("FAIL copy_read0 got addr=%h we=%b exp addr=10 we=0", addr, we);
        end
        bc0 = busy ? 1 : 0;
        step();
        total++; if (addr !== 8'h80 || we !== 1'b1 || wdata !== 8'd11) begin
            bad++;
            $display("FAIL copy_write0 got addr=%h we=%b data=%0d exp addr=80 we=1 data=11",
                     addr, we, wdata);
        end
        wait_done(2, cyc, bc);
        total++; if (cyc !== 9) begin bad++; $display("FAIL copy_latency got=%0d exp=9", cyc); end
        total++; if (bc + bc0 !== 8) begin
            bad++; $display("FAIL copy_busy_cycles got=%0d exp=8", bc + bc0);
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL copy_busy_in_done got=%b exp=0", busy); end
        for (int i = 0; i < 4; i++) begin
            total++; if (mem[8'h80 + i] !== exp[i]) begin
                bad++; $display("FAIL copy_data[%0d] got=%0d exp=%0d", i, mem[8'h80 + i], exp[i]);
            end
        end
        total++; if (mem[8'h84] !== 8'h00) begin
            bad++; $display("FAIL copy_overrun got=%h exp=00", mem[8'h84]);
        end
        step();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL copy_done_pulse got=%b exp=0", done); end
    endtask

    task automatic test_zero_len();
        int we_seen = 0;
        mem[8'h30] = 8'hC3;
        start_op(8'h20, 8'h30, 8'd0);
        total++; if (done !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL zero_done got done=%b busy=%b exp done=1 busy=0", done, busy);
        end
        for (int i = 0; i < 4; i++) begin
            if (we) we_seen++;
            step();
        end
        total++; if (we_seen !== 0) begin bad++; $display("FAIL zero_we got=%0d exp=0", we_seen); end
        total++; if (mem[8'h30] !== 8'hC3) begin
            bad++; $display("FAIL zero_mem got=%h exp=c3", mem[8'h30]);
        end
    endtask

    task automatic test_wrap();
        int cyc, bc;
        mem[8'hFE] = 8'h0A; mem[8'hFF] = 8'h0B; mem[8'h00] = 8'h0C;
        start_op(8'hFE, 8'h02, 8'd3);
        wait_done(1, cyc, bc);
        total++; if (cyc !== 7) begin bad++; $display("FAIL wrap_latency got=%0d exp=7", cyc); end
        total++; if (mem[8'h02] !== 8'h0A || mem[8'h03] !== 8'h0B || mem[8'h04] !== 8'h0C) begin
            bad++; $display("FAIL wrap_data got=%h %h %h exp=0a 0b 0c",
                            mem[8'h02], mem[8'h03], mem[8'h04]);
        end
        step();
    endtask

    task automatic test_mid_reset();
        int cyc, bc;
        for (int i = 0; i < 8; i++) begin
            mem[8'h50 + i] = 8'h61 + 8'(i);
            mem[8'h90 + i] = 8'h00;
        end
        mem[8'hA0] = 8'h00;
        start_op(8'h50, 8'h90, 8'd8);
        for (int i = 0; i < 4; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++; if (busy !== 1'b0 || we !== 1'b0) begin
            bad++; $display("FAIL midrst_idle got busy=%b we=%b exp 0 0", busy, we);
        end
        total++; if (mem[8'h90] !== 8'h61 || mem[8'h91] !== 8'h62 || mem[8'h92] !== 8'h00) begin
            bad++; $display("FAIL midrst_partial got=%h %h %h exp=61 62 00",
                            mem[8'h90], mem[8'h91], mem[8'h92]);
        end
        start_op(8'h50, 8'hA0, 8'd1);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL midrst_restart got=%b exp=1", busy); end
        wait_done(1, cyc, bc);
        total++; if (cyc !== 3 || mem[8'hA0] !== 8'h61) begin
            bad++; $display("FAIL midrst_copy got cyc=%0d data=%h exp cyc=3 data=61", cyc, mem[8'hA0]);
        end
        step();
    endtask

    task automatic test_start_busy();
        int done_cnt = 0, done_cyc = 0;
        for (int i = 0; i < 4; i++) mem[8'hB0 + i] = 8'h00;
        mem[8'hC0] = 8'h00;
        start_op(8'h10, 8'hB0, 8'd4);
        for (int c = 1; c <= 14; c++) begin
            if (done) begin done_cnt++; done_cyc = c; end
            if (c == 3) begin
                src = 8'h50; dst = 8'hC0; len = 8'd2; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            step();
        end
        total++; if (done_cnt !== 1 || done_cyc !== 9) begin
            bad++; $display("FAIL busy_start_done got cnt=%0d cyc=%0d exp cnt=1 cyc=9", done_cnt, done_cyc);
        end
        total++; if (mem[8'hB0] !== 8'd11 || mem[8'hB3] !== 8'd44 || mem[8'hC0] !== 8'h00) begin
            bad++; $display("FAIL busy_start_data got=%0d %0d %h exp=11 44 00",
                            mem[8'hB0], mem[8'hB3], mem[8'hC0]);
        end
    endtask

`ifdef COPY_FILL_EN
    task automatic test_fill();
        int cyc, bc;
        for (int i = 0; i < 6; i++) mem[8'h40 + i] = 8'h00;
        fill = 1'b1; fill_value = 8'h5A;
        start_op(8'h00, 8'h40, 8'd5);
        fill = 1'b0;
        wait_done(1, cyc, bc);
        total++; if (cyc !== 6 || bc !== 5) begin
            bad++; $display("FAIL fill_latency got cyc=%0d busy=%0d exp cyc=6 busy=5", cyc, bc);
        end
        for (int i = 0; i < 5; i++) begin
            total++; if (mem[8'h40 + i] !== 8'h5A) begin
                bad++; $display("FAIL fill_data[%0d] got=%h exp=5a", i, mem[8'h40 + i]);
            end
        end
        total++; if (mem[8'h45] !== 8'h00) begin
            bad++; $display("FAIL fill_overrun got=%h exp=00", mem[8'h45]);
        end
        step();
    endtask
`endif

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        test_reset();
        test_copy();
        test_zero_len();
        test_wrap();
        test_mid_reset();
        test_start_busy();
`ifdef COPY_FILL_EN
        test_fill();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
